// File: rtl/wb_intercon_pkg.sv
// Shared types and limits for the Wishbone shared-bus interconnect.
// No logic; arbiter state encoding, stall counter width and legal master/slave counts.
package wb_intercon_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_t;

    localparam int CNT_W  = 16;
    localparam int NM_MIN = 1;
    localparam int NM_MAX = 4;
    localparam int NS_MIN = 1;
    localparam int NS_MAX = 16;

    // Index width that stays at least one bit for single-entry buses.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Round-robin master arbiter: grant registered one cycle after load, cleared on clr.
// No backpressure; the last-owner register doubles as the current owner index.
module wb_rr_arb
    import wb_intercon_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = idx_w(NM)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rstn_i,
    input  logic [NM-1:0] req,
    input  logic          load,
    input  logic          clr,
    output logic [NM-1:0] grant,
    output logic [IW-1:0] owner
);

    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic          found;

    // Scan the furthest offset first so the nearest requester after last wins.
    always_comb begin
        pick  = last;
        found = 1'b0;
        for (int k = NM; k >= 1; k--) begin
            for (int i = 0; i < NM; i++) begin
                if (req[i] && (i == (int'(last) + k) % NM)) begin
                    pick  = IW'(i);
                    found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            grant <= '0;
            last  <= IW'(NM - 1);
        end else if (load && found) begin
            grant <= NM'(1) << pick;
            last  <= pick;
        end else if (clr) begin
            grant <= '0;
        end
    end

    assign owner = last;

endmodule

// File: rtl/wb_intercon.sv
// Shared-bus Wishbone interconnect: round-robin masters, mask/base slave decode, stall timeout.
// Zero added latency once owned (one cycle to win the bus); unmapped and timed-out cycles end in a registered err.
module wb_intercon
    import wb_intercon_pkg::*;
#(
    parameter int               NM       = 2,
    parameter int               NS       = 9,
    parameter logic [NS*32-1:0] SLV_BASE = '0,
    parameter logic [NS*32-1:0] SLV_MASK = '0,
    parameter int               TIMEOUT  = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic [NM*32-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_cyc_i,
    output logic [31:0]      m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*32-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    output logic [NM-1:0]    grant_o
);

    localparam int MW = idx_w(NM);
    localparam int SW = idx_w(NS);

    if (NM < NM_MIN || NM > NM_MAX) begin : g_bad_nm
        $error("wb_intercon: NM out of range");
    end
    if (NS < NS_MIN || NS > NS_MAX) begin : g_bad_ns
        $error("wb_intercon: NS out of range");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_to
        $error("wb_intercon: TIMEOUT out of range");
    end

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             gnt_load;
    logic             gnt_clr;
    logic [NM-1:0]    grant;
    logic [MW-1:0]    own_idx;
    logic             has_owner;
    logic             own_cyc;
    logic             own_stb;
    logic [SW-1:0]    sel_idx;
    logic             hit;
    logic             bus_act;
    logic             sel_ack;
    logic             stall;
    logic             timeout;
    logic             unmapped;
    logic [CNT_W-1:0] stall_cnt;
    logic [NM-1:0]    err_q;

    wb_rr_arb #(
        .NM (NM),
        .IW (MW)
    ) u_arb (
        .wb_clk_i  (wb_clk_i),
        .wb_rstn_i (wb_rstn_i),
        .req       (m_cyc_i),
        .load      (gnt_load),
        .clr       (gnt_clr),
        .grant     (grant),
        .owner     (own_idx)
    );

    assign has_owner = |grant;
    assign grant_o   = grant;
    assign m_err_o   = err_q;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (has_owner) begin
            s_adr_o = m_adr_i[32*own_idx +: 32];
            s_dat_o = m_dat_i[32*own_idx +: 32];
            s_sel_o = m_sel_i[4*own_idx +: 4];
            s_we_o  = m_we_i[own_idx];
            own_cyc = m_cyc_i[own_idx];
            own_stb = m_stb_i[own_idx];
        end
    end

    // Descending scan leaves the lowest matching slave index selected.
    always_comb begin
        hit     = 1'b0;
        sel_idx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((s_adr_o & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit     = has_owner;
                sel_idx = SW'(i);
            end
        end
    end

    assign bus_act  = (state == ARB_OWN) && hit && own_cyc;
    assign sel_ack  = s_ack_i[sel_idx];
    assign stall    = bus_act && own_stb && !sel_ack;
    assign timeout  = stall && ((stall_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));
    // A pending err already terminates this strobe, so it must not re-arm.
    assign unmapped = (state == ARB_OWN) && has_owner && own_cyc && own_stb && !hit && !(|err_q);
    assign m_dat_o  = hit ? s_dat_i[32*sel_idx +: 32] : 32'h0;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_load  = 1'b0;
        gnt_clr   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|m_cyc_i) begin
                    state_nxt = ARB_OWN;
                    gnt_load  = 1'b1;
                end
            end
            ARB_OWN: begin
                if (!own_cyc) begin
                    state_nxt = ARB_IDLE;
                    gnt_clr   = 1'b1;
                end else if (timeout) begin
                    state_nxt = ARB_ABORT;
                end
            end
            ARB_ABORT: begin
                if (!own_cyc) begin
                    state_nxt = ARB_IDLE;
                    gnt_clr   = 1'b1;
                end else if (!own_stb) begin
                    state_nxt = ARB_OWN;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                gnt_clr   = 1'b1;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        m_ack_o = '0;
        if (bus_act) begin
            s_cyc_o[sel_idx] = 1'b1;
            s_stb_o[sel_idx] = own_stb;
            if (own_stb && sel_ack) begin
                m_ack_o = grant;
            end
        end
    end

    // Counter only runs on acked-less strobes in OWN; every other case clears it.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            stall_cnt <= '0;
            err_q     <= '0;
        end else begin
            err_q <= (timeout || unmapped) ? grant : '0;
            if (stall && !timeout) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/wb_intercon.md
WB_INTERCON -- requirements
Module: wb_intercon

Interface
REQ-001 Parameter NM, default 2: number of Wishbone masters, legal 1..4.
REQ-002 Parameter NS, default 9: number of Wishbone slaves, legal 1..16.
REQ-003 Parameter SLV_BASE, default all-zero: NS*32-bit packed base addresses, slave i at bits [32i+31:32i].
REQ-004 Parameter SLV_MASK, default all-zero: NS*32-bit packed decode masks, same packing as SLV_BASE.
REQ-005 Parameter TIMEOUT, default 255: stall cycles before a bus error, legal 2..65535.
REQ-006 wb_clk_i  in  1  bus clock; single clock domain.
REQ-007 wb_rstn_i  in  1  asynchronous active-low reset.
REQ-008 m_adr_i, m_dat_i  in  NM*32 each  master address and write data.
REQ-009 m_sel_i  in  NM*4  master byte selects.
REQ-010 m_we_i, m_stb_i, m_cyc_i  in  NM each  master write enable, strobe and cycle.
REQ-011 m_dat_o  out  32  read data, broadcast to all masters.
REQ-012 m_ack_o, m_err_o  out  NM each  per-master acknowledge and bus error.
REQ-013 s_adr_o, s_dat_o  out  32 each  shared slave address and write data.
REQ-014 s_sel_o  out  4  shared slave byte selects.
REQ-015 s_we_o  out  1  shared slave write enable.
REQ-016 s_cyc_o, s_stb_o  out  NS each  per-slave cycle and strobe.
REQ-017 s_dat_i  in  NS*32  slave read data.
REQ-018 s_ack_i  in  NS  slave acknowledges.
REQ-019 grant_o  out  NM  one-hot current owner, all-zero when idle.

Function
REQ-020 The arbiter SHALL have three states: IDLE, OWN, ABORT.
REQ-021 IDLE: when any m_cyc_i is high, the arbiter SHALL register a grant to the first requester after the last owner (round-robin) and enter OWN on the next edge.
REQ-022 OWN: when the owner's cyc goes low, the arbiter SHALL enter IDLE; a new grant SHALL issue no earlier than one cycle later.
REQ-023 Owner adr/dat/sel/we SHALL drive the s_* shared signals; with no owner they SHALL be 0.
REQ-024 Decode: slave i is selected when (adr & MASK_i) == BASE_i; the lowest matching index SHALL win; decode is combinational from the owner's address.
REQ-025 s_cyc_o/s_stb_o SHALL assert only for the selected slave, only in OWN, gated combinationally by the owner's cyc/stb.
REQ-026 m_dat_o SHALL be the selected slave's s_dat_i, else 32'h0 (never Z).
REQ-027 m_ack_o SHALL route the selected slave's ack to the owner only; non-owners SHALL see ack=err=0.
REQ-028 Unmapped address with owner stb high: m_err_o[owner] SHALL pulse one cycle, registered, exactly one cycle after stb is sampled.
REQ-029 A 16-bit stall counter SHALL count cycles with stb high and no ack from the selected slave, and SHALL clear on ack, on stb low and on ownership change.
REQ-030 When the counter reaches TIMEOUT, the block SHALL pulse m_err_o[owner] for one cycle and enter ABORT.
REQ-031 ABORT: s_cyc_o/s_stb_o SHALL be 0 and slave acks SHALL be ignored; on owner stb low the arbiter SHALL enter OWN, and on owner cyc low it SHALL enter IDLE.
REQ-032 Ack and timeout in the same cycle: the ack SHALL win, with no error and no ABORT.
REQ-033 With NM=1 the arbiter SHALL still take the registered IDLE->OWN cycle.

Reset
REQ-034 On wb_rstn_i low, asynchronously: state IDLE, grant 0, last owner NM-1 (master 0 gets first priority), counter 0, all outputs 0.
REQ-035 Reset asserted mid-transfer SHALL drop all s_cyc_o/s_stb_o immediately; no ack or err SHALL follow release.

Structure
REQ-036 A shared package SHALL hold the arbiter state encoding, the timeout counter width (16) and the legal NM/NS bounds.
REQ-037 Round-robin grant logic SHALL live in one sub-module, wb_rr_arb (NM request in, one-hot grant out, last-owner register).

Verification
REQ-038 NS=3, bases 0x0/0x2000_0000/0xF000_0000, masks 0xF000_0000: master0 reads 0x2000_0010, slave1 acks with 0xCAFEBABE -> only s_stb_o[1] high; m_ack_o[0]=1; m_dat_o=0xCAFEBABE.
REQ-039 Both masters raise cyc in the same cycle from reset -> grant 01; after master0 releases, grant 10 follows one idle cycle later.
REQ-040 Master0 stb to 0x7000_0000 (unmapped) -> m_err_o[0] one-cycle pulse one cycle after stb; no s_stb_o asserted.
REQ-041 TIMEOUT=4, slave never acks -> m_err_o[0] after 4 stall cycles; s_stb_o drops in ABORT; a new stb to another slave completes normally.
REQ-042 Ack arrives in the cycle the counter hits TIMEOUT -> ack only, no err; next transfer unaffected.
REQ-043 wb_rstn_i pulsed low mid-transfer -> all outputs 0 that cycle; master0 granted first after release.
